// File: rtl/renode_ahb_sram_subordinate.sv
// ============================================================================
// Module   : renode_ahb_sram_subordinate
// Purpose  : AHB-Lite subordinate backed by a word-organised SRAM. Decodes the
//            address and data phases, inserts WaitStates wait cycles on every
//            OKAY data phase, honours byte strobes, and answers illegal
//            transfers with the two-cycle ERROR response.
// Ports    : hclk, hreset (async, active-high)
//            hsel, haddr, htrans, hwrite, hsize, hburst, hready  - address phase
//            hwdata, hwstrb                                      - write data phase
//            hreadyout, hresp, hrdata                            - response
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module renode_ahb_sram_subordinate #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int DepthWords   = 1024,
    parameter int WaitStates   = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [AddressWidth-1:0] haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic                    hready,
    input  logic [DataWidth-1:0]    hwdata,
    input  logic [DataWidth/8-1:0]  hwstrb,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DataWidth-1:0]    hrdata
);

    localparam int NBYTES     = DataWidth / 8;
    localparam int BYTE_SHIFT = $clog2(NBYTES);
    localparam int INDEX_W    = (DepthWords > 1) ? $clog2(DepthWords) : 1;
    localparam logic [AddressWidth:0] BYTE_RANGE = (AddressWidth + 1)'(DepthWords * NBYTES);
    localparam logic [3:0] WAIT_LOAD  = 4'(WaitStates);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pend_q, pend_d;    // a data phase is outstanding
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                    write_q, write_d;
    logic [2:0]              size_q, size_d;
    logic                    err_q, err_d;

    logic [DataWidth-1:0]    mem_q [DepthWords];

    logic                    w_ready_cycle;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_addr_err;
    logic [AddressWidth-1:0] w_align_mask;
    logic [AddressWidth-1:0] w_word_addr;
    logic [INDEX_W-1:0]      w_index;
    logic [31:0]             w_byte_off;
    logic [NBYTES-1:0]       w_lane_mask;
    logic [DataWidth-1:0]    w_rdata;
    logic                    w_unused;

    // Burst type is irrelevant (every beat decoded on its own) and htrans[0]
    // only distinguishes SEQ from NONSEQ, which behave identically here.
    assign w_unused = ^{hburst, htrans[0], w_word_addr};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    // New address phases are only taken in a cycle where this block itself
    // reports ready (IDLE, or the second ERROR cycle).
    assign w_ready_cycle = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign w_accept      = hsel & hready & htrans[1] & w_ready_cycle;

    assign w_align_mask  = ~({AddressWidth{1'b1}} << hsize);
    assign w_addr_err    = ({1'b0, haddr} >= BYTE_RANGE)
                         || (hsize > 3'(BYTE_SHIFT))
                         || (|(haddr & w_align_mask));

    // ------------------------------------------------------------------
    // Data-phase decode from the registered address
    // ------------------------------------------------------------------
    // Only an OKAY transfer ever reaches IDLE with a pending data phase;
    // erroring transfers are parked in ERR1/ERR2.
    assign w_complete  = (state_q == S_IDLE) && pend_q && !err_q;
    assign w_word_addr = addr_q >> BYTE_SHIFT;
    assign w_index     = w_word_addr[INDEX_W-1:0];
    assign w_byte_off  = 32'(addr_q) & 32'(NBYTES - 1);

    // A byte lane is active when it falls inside the naturally aligned
    // container of the transfer size that holds the addressed byte.
    always_comb begin
        w_lane_mask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            w_lane_mask[b] = ((32'(b) >> size_q) == (w_byte_off >> size_q));
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_complete && !write_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_lane_mask[b]) begin
                    w_rdata[8*b +: 8] = mem_q[w_index][8*b +: 8];
                end
            end
        end
    end

    assign hrdata    = w_rdata;
    assign hreadyout = w_ready_cycle;
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_ERR2: begin
                pend_d  = w_accept;
                state_d = S_IDLE;
                if (w_accept) begin
                    addr_d  = haddr;
                    write_d = hwrite;
                    size_d  = hsize;
                    err_d   = w_addr_err;
                    if (w_addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_LOAD != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // At a count of 1 the next cycle is the completing one.
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset so contents survive hreset. A reset clears pend_q
    // asynchronously, so an interrupted write can never commit.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (w_complete && write_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (hwstrb[b] && w_lane_mask[b]) begin
                    mem_q[w_index][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_renode_ahb_sram_subordinate.sv
// ============================================================================
// Module   : tb_renode_ahb_sram_subordinate
// Purpose  : Directed self-checking bench. Instance 0 runs with no wait
//            states, instance 1 with three; each has its own bus signals and
//            hready looped back from its own hreadyout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_renode_ahb_sram_subordinate;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic        hready    [2];
    logic [31:0] hwdata    [2];
    logic [3:0]  hwstrb    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 hclk = ~hclk;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    renode_ahb_sram_subordinate #(
        .AddressWidth(32), .DataWidth(32), .DepthWords(1024), .WaitStates(0)
    ) u_dut_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr[0]),
        .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
        .hburst(hburst[0]), .hready(hready[0]), .hwdata(hwdata[0]),
        .hwstrb(hwstrb[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]),
        .hrdata(hrdata[0])
    );

    renode_ahb_sram_subordinate #(
        .AddressWidth(32), .DataWidth(32), .DepthWords(1024), .WaitStates(3)
    ) u_dut_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr[1]),
        .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
        .hburst(hburst[1]), .hready(hready[1]), .hwdata(hwdata[1]),
        .hwstrb(hwstrb[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]),
        .hrdata(hrdata[1])
    );

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
        haddr[d]  = 32'h0;
        hsize[d]  = 3'd0;
    endtask

    task automatic addr_phase(input int d, input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = a;
        hwrite[d] = w;
        hsize[d]  = s;
    endtask

    // One isolated transfer; returns what the data phase looked like.
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output int waits,
                        output logic resp_first, output logic resp_last, output logic early_zero);
        addr_phase(d, a, w, s);
        step();
        bus_idle(d);
        hwdata[d]  = wd;
        hwstrb[d]  = st;
        resp_first = hresp[d];
        early_zero = 1'b1;
        waits      = 0;
        while (hreadyout[d] !== 1'b1 && waits < 40) begin
            if (hrdata[d] !== 32'h0) early_zero = 1'b0;
            step();
            waits++;
        end
        rd        = hrdata[d];
        resp_last = hresp[d];
        step();
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (2) step();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (hreadyout[d] !== 1'b1) $display("FAIL reset_hreadyout[%0d]: got %b expected 1", d, hreadyout[d]);
            else n_pass++;
            n_total++;
            if (hresp[d] !== 1'b0) $display("FAIL reset_hresp[%0d]: got %b expected 0", d, hresp[d]);
            else n_pass++;
            n_total++;
            if (hrdata[d] !== 32'h0) $display("FAIL reset_hrdata[%0d]: got %h expected 00000000", d, hrdata[d]);
            else n_pass++;
        end
        hreset = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        addr_phase(0, 32'h10, 1'b1, 3'd2);
        step();
        hwdata[0] = 32'hDEADBEEF;
        hwstrb[0] = 4'hF;
        addr_phase(0, 32'h10, 1'b0, 3'd2);
        n_total++;
        if (hreadyout[0] !== 1'b1) $display("FAIL b2b_write_ready: got %b expected 1", hreadyout[0]);
        else n_pass++;
        step();
        bus_idle(0);
        n_total++;
        if (hreadyout[0] !== 1'b1) $display("FAIL b2b_read_ready: got %b expected 1", hreadyout[0]);
        else n_pass++;
        n_total++;
        if (hresp[0] !== 1'b0) $display("FAIL b2b_read_resp: got %b expected 0", hresp[0]);
        else n_pass++;
        n_total++;
        if (hrdata[0] !== 32'hDEADBEEF) $display("FAIL b2b_read_data: got %h expected deadbeef", hrdata[0]);
        else n_pass++;
        step();
        n_total++;
        if (hrdata[0] !== 32'h0) $display("FAIL b2b_rdata_after: got %h expected 00000000", hrdata[0]);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        int          waits;
        logic        rf, rl, ez;
        xfer(1, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF, rd, waits, rf, rl, ez);
        n_total++;
        if (waits != 3) $display("FAIL ws3_write_waits: got %0d expected 3", waits);
        else n_pass++;
        xfer(1, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (waits != 3) $display("FAIL ws3_read_waits: got %0d expected 3", waits);
        else n_pass++;
        n_total++;
        if (ez !== 1'b1) $display("FAIL ws3_rdata_zero_while_waiting: got %b expected 1", ez);
        else n_pass++;
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL ws3_read_data: got %h expected deadbeef", rd);
        else n_pass++;
        n_total++;
        if (rl !== 1'b0) $display("FAIL ws3_read_resp: got %b expected 0", rl);
        else n_pass++;
    endtask

    task automatic test_byte_strobes();
        logic [31:0] rd;
        int          waits;
        logic        rf, rl, ez;
        xfer(0, 32'h11, 1'b1, 3'd0, 32'h3344AA11, 4'hF, rd, waits, rf, rl, ez);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'hDEADAAEF) $display("FAIL byte_write_lane1: got %h expected deadaaef", rd);
        else n_pass++;
        n_total++;
        if (waits != 0) $display("FAIL ws0_read_waits: got %0d expected 0", waits);
        else n_pass++;
        xfer(0, 32'h10, 1'b1, 3'd2, 32'h12345678, 4'h3, rd, waits, rf, rl, ez);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'hDEAD5678) $display("FAIL strobe_0x3_write: got %h expected dead5678", rd);
        else n_pass++;
        xfer(0, 32'h12, 1'b0, 3'd1, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'hDEAD0000) $display("FAIL halfword_read_0x12: got %h expected dead0000", rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        int          waits;
        logic        rf, rl, ez;
        logic [31:0] a_tab [3];
        logic [2:0]  s_tab [3];
        logic        w_tab [3];
        a_tab[0] = 32'd4096; s_tab[0] = 3'd2; w_tab[0] = 1'b0;
        a_tab[1] = 32'h3;    s_tab[1] = 3'd1; w_tab[1] = 1'b1;
        a_tab[2] = 32'h0;    s_tab[2] = 3'd3; w_tab[2] = 1'b1;
        xfer(1, 32'h0, 1'b1, 3'd2, 32'h01020304, 4'hF, rd, waits, rf, rl, ez);
        for (int i = 0; i < 3; i++) begin
            xfer(1, a_tab[i], w_tab[i], s_tab[i], 32'hFFFFFFFF, 4'hF, rd, waits, rf, rl, ez);
            n_total++;
            if (waits != 1) $display("FAIL err%0d_low_cycles: got %0d expected 1", i, waits);
            else n_pass++;
            n_total++;
            if (rf !== 1'b1) $display("FAIL err%0d_resp_first: got %b expected 1", i, rf);
            else n_pass++;
            n_total++;
            if (rl !== 1'b1) $display("FAIL err%0d_resp_second: got %b expected 1", i, rl);
            else n_pass++;
            n_total++;
            if (rd !== 32'h0) $display("FAIL err%0d_rdata: got %h expected 00000000", i, rd);
            else n_pass++;
        end
        xfer(1, 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'h01020304) $display("FAIL err_mem_unchanged: got %h expected 01020304", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        int          waits;
        logic        rf, rl, ez;
        xfer(1, 32'h20, 1'b1, 3'd2, 32'hCAFEF00D, 4'hF, rd, waits, rf, rl, ez);
        addr_phase(1, 32'h20, 1'b1, 3'd2);
        step();
        bus_idle(1);
        hwdata[1] = 32'h0BADBEEF;
        hwstrb[1] = 4'hF;
        n_total++;
        if (hreadyout[1] !== 1'b0) $display("FAIL rst_wait1_ready: got %b expected 0", hreadyout[1]);
        else n_pass++;
        step();
        #2;
        hreset = 1'b1;
        #1;
        n_total++;
        if (hreadyout[1] !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", hreadyout[1]);
        else n_pass++;
        n_total++;
        if (hresp[1] !== 1'b0) $display("FAIL rst_mid_resp: got %b expected 0", hresp[1]);
        else n_pass++;
        n_total++;
        if (hrdata[1] !== 32'h0) $display("FAIL rst_mid_rdata: got %h expected 00000000", hrdata[1]);
        else n_pass++;
        repeat (2) step();
        hreset = 1'b0;
        step();
        xfer(1, 32'h20, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'hCAFEF00D) $display("FAIL rst_write_dropped: got %h expected cafef00d", rd);
        else n_pass++;
        xfer(1, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rst_mem_preserved: got %h expected deadbeef", rd);
        else n_pass++;
    endtask

    task automatic test_no_accept();
        logic [31:0] rd;
        int          waits;
        logic        rf, rl, ez;
        hwdata[0] = 32'hFFFFFFFF;
        hwstrb[0] = 4'hF;
        // Cases: IDLE with hsel, BUSY with hsel, NONSEQ without hsel, then a
        // quiet cycle where an accepted transfer would have its data phase.
        for (int i = 0; i < 4; i++) begin
            hsel[0]   = (i < 2);
            htrans[0] = (i == 3) ? 2'b00 : 2'(i);
            haddr[0]  = 32'h10;
            hwrite[0] = 1'b1;
            hsize[0]  = 3'd2;
            step();
            n_total++;
            if (hreadyout[0] !== 1'b1) $display("FAIL noacc%0d_ready: got %b expected 1", i, hreadyout[0]);
            else n_pass++;
            n_total++;
            if (hresp[0] !== 1'b0) $display("FAIL noacc%0d_resp: got %b expected 0", i, hresp[0]);
            else n_pass++;
            n_total++;
            if (hrdata[0] !== 32'h0) $display("FAIL noacc%0d_rdata: got %h expected 00000000", i, hrdata[0]);
            else n_pass++;
        end
        bus_idle(0);
        step();
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd, waits, rf, rl, ez);
        n_total++;
        if (rd !== 32'hDEAD5678) $display("FAIL noacc_no_write: got %h expected dead5678", rd);
        else n_pass++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            hburst[d] = 3'd0;
            hwdata[d] = 32'h0;
            hwstrb[d] = 4'h0;
        end
        hreset = 1'b1;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_strobes();
        test_errors();
        test_reset_mid_write();
        test_no_accept();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
